// File: rtl/axis_vc_serializer_shim_in.sv
// Multi-VC AXI-Stream to credit-flow NoC flit serializer with per-VC word FIFOs.
// Optional AXIS_SER_TRIM_EN adds axis_tkeep and trims trailing empty flits of tlast words.
module axis_vc_serializer_shim_in #(
    parameter int NUM_VC               = 4,
    parameter int TDEST_WIDTH          = 3,
    parameter int TDATA_WIDTH          = 512,
    parameter int SERIALIZATION_FACTOR = 4,
    parameter int BUFFER_DEPTH         = 4,
    parameter int FLIT_BUFFER_DEPTH    = 4,
    localparam int FW = TDATA_WIDTH / SERIALIZATION_FACTOR,
    localparam int VW = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
    input  logic                          clk_noc,
    input  logic                          rst_n_noc,
    input  logic [NUM_VC-1:0]             axis_tvalid,
    output logic [NUM_VC-1:0]             axis_tready,
    input  logic [NUM_VC*TDATA_WIDTH-1:0] axis_tdata,
    input  logic [NUM_VC-1:0]             axis_tlast,
    input  logic [NUM_VC*TDEST_WIDTH-1:0] axis_tdest,
`ifdef AXIS_SER_TRIM_EN
    input  logic [NUM_VC*TDATA_WIDTH/8-1:0] axis_tkeep,
`endif
    output logic [FW-1:0]                 data_out,
    output logic [TDEST_WIDTH-1:0]        dest_out,
    output logic [VW-1:0]                 vc_out,
    output logic                          is_tail_out,
    output logic                          send_out,
    input  logic [NUM_VC-1:0]             credit_in
);
    localparam int IW  = $clog2(SERIALIZATION_FACTOR);
    localparam int AW  = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
    localparam int CW  = $clog2(FLIT_BUFFER_DEPTH) + 1;
    localparam int KW  = TDATA_WIDTH / 8;
    localparam int KPF = FW / 8;
`ifdef AXIS_SER_TRIM_EN
    localparam int WW = KW + TDEST_WIDTH + 1 + TDATA_WIDTH;
`else
    localparam int WW = TDEST_WIDTH + 1 + TDATA_WIDTH;
`endif

    logic [WW-1:0]          mem [NUM_VC][BUFFER_DEPTH];
    logic [WW-1:0]          word_in [NUM_VC];
    logic [AW-1:0]          wr_ptr [NUM_VC];
    logic [AW-1:0]          rd_ptr [NUM_VC];
    logic [AW:0]            count [NUM_VC];
    logic [CW-1:0]          cnt [NUM_VC];
    logic [NUM_VC-1:0]      push, pop, sent, elig, rdy;
    logic [IW-1:0]          flit_idx, last_idx;
    logic [VW-1:0]          rr_ptr, lock_vc, gnt_vc, nxt_ptr;
    logic                   gnt_valid, is_last;
    logic [WW-1:0]          head;
    logic [TDATA_WIDTH-1:0] head_data;
    logic [TDEST_WIDTH-1:0] head_dest;
    logic                   head_last;
    logic [FW-1:0]          flit;
    int                     j;

    function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
        return (p == AW'(BUFFER_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        for (int v = 0; v < NUM_VC; v++) begin
            rdy[v]  = count[v] != (AW+1)'(BUFFER_DEPTH);
            push[v] = axis_tvalid[v] && rdy[v];
            elig[v] = (count[v] != '0) && (cnt[v] != '0);
`ifdef AXIS_SER_TRIM_EN
            word_in[v] = {axis_tkeep[v*KW +: KW],
                          axis_tdest[v*TDEST_WIDTH +: TDEST_WIDTH],
                          axis_tlast[v],
                          axis_tdata[v*TDATA_WIDTH +: TDATA_WIDTH]};
`else
            word_in[v] = {axis_tdest[v*TDEST_WIDTH +: TDEST_WIDTH],
                          axis_tlast[v],
                          axis_tdata[v*TDATA_WIDTH +: TDATA_WIDTH]};
`endif
        end
        axis_tready = rdy;
    end

    // Mid-word the locked VC owns the link even when it has no credits.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_vc    = lock_vc;
        j         = 0;
        if (flit_idx != '0) begin
            gnt_valid = cnt[lock_vc] != '0;
        end else begin
            for (int i = 0; i < NUM_VC; i++) begin
                j = (int'(rr_ptr) + i) % NUM_VC;
                if (!gnt_valid && elig[j]) begin
                    gnt_valid = 1'b1;
                    gnt_vc    = VW'(j);
                end
            end
        end
        nxt_ptr = (gnt_vc == VW'(NUM_VC - 1)) ? '0 : gnt_vc + 1'b1;
    end

    always_comb begin
        head      = mem[gnt_vc][rd_ptr[gnt_vc]];
        head_data = head[TDATA_WIDTH-1:0];
        head_last = head[TDATA_WIDTH];
        head_dest = head[TDATA_WIDTH+1 +: TDEST_WIDTH];
        flit      = head_data[flit_idx*FW +: FW];
        last_idx  = IW'(SERIALIZATION_FACTOR - 1);
`ifdef AXIS_SER_TRIM_EN
        if (head_last) begin
            last_idx = '0;
            for (int i = 0; i < SERIALIZATION_FACTOR; i++)
                if (|head[WW-1-KW+1+i*KPF +: KPF]) last_idx = IW'(i);
        end
`endif
        is_last = flit_idx == last_idx;
        for (int v = 0; v < NUM_VC; v++) begin
            sent[v] = gnt_valid && (gnt_vc == VW'(v));
            pop[v]  = sent[v] && is_last;
        end
    end

    always_ff @(posedge clk_noc) begin
        for (int v = 0; v < NUM_VC; v++)
            if (push[v]) mem[v][wr_ptr[v]] <= word_in[v];
    end

    always_ff @(posedge clk_noc or negedge rst_n_noc) begin
        if (!rst_n_noc) begin
            for (int v = 0; v < NUM_VC; v++) begin
                wr_ptr[v] <= '0;
                rd_ptr[v] <= '0;
                count[v]  <= '0;
                cnt[v]    <= CW'(FLIT_BUFFER_DEPTH);
            end
            flit_idx    <= '0;
            rr_ptr      <= '0;
            lock_vc     <= '0;
            data_out    <= '0;
            dest_out    <= '0;
            vc_out      <= '0;
            is_tail_out <= 1'b0;
            send_out    <= 1'b0;
        end else begin
            for (int v = 0; v < NUM_VC; v++) begin
                if (push[v]) wr_ptr[v] <= inc(wr_ptr[v]);
                if (pop[v])  rd_ptr[v] <= inc(rd_ptr[v]);
                count[v] <= count[v] + (AW+1)'(push[v]) - (AW+1)'(pop[v]);
                // Excess credit saturates instead of wrapping.
                if (credit_in[v] && !sent[v]) begin
                    if (cnt[v] != CW'(FLIT_BUFFER_DEPTH)) cnt[v] <= cnt[v] + 1'b1;
                end else if (!credit_in[v] && sent[v]) begin
                    cnt[v] <= cnt[v] - 1'b1;
                end
            end
            send_out    <= gnt_valid;
            data_out    <= gnt_valid ? flit : '0;
            dest_out    <= gnt_valid ? head_dest : '0;
            vc_out      <= gnt_valid ? gnt_vc : '0;
            is_tail_out <= gnt_valid && is_last && head_last;
            if (gnt_valid) begin
                flit_idx <= is_last ? '0 : flit_idx + 1'b1;
                if (flit_idx == '0) begin
                    lock_vc <= gnt_vc;
                    rr_ptr  <= nxt_ptr;
                end
            end
        end
    end

`ifndef SYNTHESIS
    for (genvar g = 0; g < NUM_VC; g++) begin : g_chk
        credit_overflow: assert property (@(posedge clk_noc) disable iff (!rst_n_noc)
            !(credit_in[g] && !sent[g] && cnt[g] == CW'(FLIT_BUFFER_DEPTH)));
    end
`endif
endmodule

// File: tb/tb_axis_vc_serializer_shim_in.sv
// Directed bench for axis_vc_serializer_shim_in (default build and AXIS_SER_TRIM_EN).
module tb_axis_vc_serializer_shim_in;
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [3:0]    tvalid = '0;
    logic [3:0]    tready;
    logic [2047:0] tdata = '0;
    logic [3:0]    tlast = '0;
    logic [11:0]   tdest = '0;
`ifdef AXIS_SER_TRIM_EN
    logic [255:0]  tkeep = '0;
`endif
    logic [127:0]  data_out;
    logic [2:0]    dest_out;
    logic [1:0]    vc_out;
    logic          is_tail_out, send_out;
    logic [3:0]    credit_in = '0;

    axis_vc_serializer_shim_in dut (
        .clk_noc(clk), .rst_n_noc(rst_n),
        .axis_tvalid(tvalid), .axis_tready(tready),
        .axis_tdata(tdata), .axis_tlast(tlast), .axis_tdest(tdest),
`ifdef AXIS_SER_TRIM_EN
        .axis_tkeep(tkeep),
`endif
        .data_out(data_out), .dest_out(dest_out), .vc_out(vc_out),
        .is_tail_out(is_tail_out), .send_out(send_out), .credit_in(credit_in)
    );

    always #5 clk = ~clk;

    int nvec = 0, nerr = 0, cyc = 0;
    bit echo = 1'b0;
    logic [127:0] q_data[$];
    logic [1:0]   q_vc[$];
    logic [2:0]   q_dest[$];
    logic         q_tail[$];
    int           q_cyc[$];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [511:0] mkword(input logic [7:0] base);
        logic [511:0] w;
        for (int b = 0; b < 64; b++) w[b*8 +: 8] = base + 8'(b);
        return w;
    endfunction

    function automatic logic [127:0] flit(input logic [7:0] base, input int i);
        logic [511:0] w;
        w = mkword(base);
        return w[i*128 +: 128];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (send_out) begin
            q_data.push_back(data_out);
            q_vc.push_back(vc_out);
            q_dest.push_back(dest_out);
            q_tail.push_back(is_tail_out);
            q_cyc.push_back(cyc);
        end
        if (echo) credit_in = send_out ? (4'b0001 << vc_out) : 4'b0000;
    endtask

    task automatic clear_q();
        q_data.delete(); q_vc.delete(); q_dest.delete();
        q_tail.delete(); q_cyc.delete();
    endtask

    task automatic release_reset();
        tvalid = '0; credit_in = '0; tlast = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        release_reset();
    endtask

    task automatic push_word(input int v, input logic [7:0] base,
                             input logic [2:0] dest, input logic last);
        int n = 0;
        while (!tready[v] && n < 50) begin step(); n++; end
        if (n >= 50) check("push_timeout", 0, 1);
        tdata[v*512 +: 512] = mkword(base);
        tdest[v*3 +: 3] = dest;
        tlast[v] = last;
        tvalid[v] = 1'b1;
        step();
        tvalid[v] = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int c;
        logic r3, r4;
        bit g3, g4;

        // 1: single word, reset state, latency
        do_reset();
        check("rst_send", send_out, 0);
        check("rst_data", data_out, 0);
        check("rst_vc", vc_out, 0);
        check("rst_dest", dest_out, 0);
        check("rst_tail", is_tail_out, 0);
        check("rst_tready", tready, 4'hF);
        clear_q();
        push_word(0, 8'h00, 3'd5, 1'b1);
        c = cyc;
        check("t1_lat_idle", send_out, 0);
        repeat (6) step();
        check("t1_nflit", q_data.size(), 4);
        if (q_data.size() == 4) begin
            check("t1_f0", q_data[0], 128'h0f0e0d0c0b0a09080706050403020100);
            check("t1_f1", q_data[1], flit(8'h00, 1));
            check("t1_f3", q_data[3], 128'h3f3e3d3c3b3a39383736353433323130);
            check("t1_tail", {q_tail[0], q_tail[1], q_tail[2], q_tail[3]}, 4'b0001);
            check("t1_vc", q_vc[3], 0);
            check("t1_dest", q_dest[0], 5);
            check("t1_first", q_cyc[0], c + 1);
            check("t1_consec", q_cyc[3] - q_cyc[0], 3);
        end

        // 2: all VCs, two words each, round robin
        do_reset();
        clear_q();
        echo = 1'b1;
        for (int v = 0; v < 4; v++) begin
            tdata[v*512 +: 512] = mkword(8'(v*64));
            tdest[v*3 +: 3] = 3'(v);
        end
        tlast = 4'h0; tvalid = 4'hF;
        step();
        for (int v = 0; v < 4; v++) tdata[v*512 +: 512] = mkword(8'(v*64 + 32));
        tlast = 4'hF;
        step();
        tvalid = 4'h0;
        repeat (40) step();
        echo = 1'b0; credit_in = '0;
        check("t2_nflit", q_data.size(), 32);
        if (q_data.size() == 32) begin
            for (int f = 0; f < 32; f++) begin
                check($sformatf("t2_vc%0d", f), q_vc[f], (f / 4) % 4);
                check($sformatf("t2_data%0d", f), q_data[f],
                      flit(8'(((f / 4) % 4) * 64 + (f / 16) * 32), f % 4));
                check($sformatf("t2_tail%0d", f), q_tail[f], (f >= 16 && f % 4 == 3));
            end
            check("t2_dest", q_dest[13], 3);
            check("t2_span", q_cyc[31] - q_cyc[0], 31);
        end

        // 3: credit exhaustion then single credit
        do_reset();
        clear_q();
        push_word(1, 8'h10, 3'd2, 1'b1);
        push_word(1, 8'h50, 3'd2, 1'b1);
        push_word(1, 8'h90, 3'd2, 1'b1);
        repeat (12) step();
        check("t3_nflit", q_data.size(), 4);
        if (q_data.size() == 4) begin
            check("t3_vc", q_vc[3], 1);
            check("t3_f3", q_data[3], flit(8'h10, 3));
        end
        check("t3_idle", send_out, 0);
        clear_q();
        credit_in[1] = 1'b1;
        step();
        credit_in = '0;
        repeat (10) step();
        check("t3_one_more", q_data.size(), 1);
        if (q_data.size() == 1) begin
            check("t3_more_vc", q_vc[0], 1);
            check("t3_more_data", q_data[0], flit(8'h50, 0));
        end

        // 4: locked VC2 with no credits blocks VC3
        do_reset();
        clear_q();
        push_word(2, 8'h20, 3'd3, 1'b1);
        push_word(2, 8'h60, 3'd3, 1'b1);
        repeat (8) step();
        credit_in[2] = 1'b1;
        step();
        credit_in = '0;
        repeat (4) step();
        check("t4_pre", q_data.size(), 5);
        clear_q();
        push_word(3, 8'hA0, 3'd4, 1'b1);
        repeat (8) step();
        check("t4_no_interleave", q_data.size(), 0);
        credit_in[2] = 1'b1;
        repeat (3) step();
        credit_in = '0;
        repeat (12) step();
        check("t4_nflit", q_data.size(), 7);
        if (q_data.size() == 7) begin
            check("t4_vcseq", {q_vc[0], q_vc[1], q_vc[2], q_vc[3], q_vc[4], q_vc[5], q_vc[6]},
                  14'b10_10_10_11_11_11_11);
            check("t4_vc2_end", q_data[2], flit(8'h60, 3));
            check("t4_vc2_tail", q_tail[2], 1);
            check("t4_vc3_f0", q_data[3], flit(8'hA0, 0));
            check("t4_vc3_dest", q_dest[3], 4);
        end

        // 5: full FIFO with zero credits
        do_reset();
        clear_q();
        push_word(0, 8'h00, 3'd1, 1'b1);
        repeat (6) step();
        clear_q();
        push_word(0, 8'h40, 3'd1, 1'b1);
        push_word(0, 8'h80, 3'd1, 1'b1);
        push_word(0, 8'hC0, 3'd1, 1'b1);
        check("t5_ready_3", tready[0], 1);
        push_word(0, 8'hE0, 3'd1, 1'b1);
        check("t5_full", tready[0], 0);
        credit_in[0] = 1'b1;
        step();
        credit_in = '0;
        repeat (6) step();
        check("t5_one_flit", q_data.size(), 1);
        check("t5_still_full", tready[0], 0);
        r3 = 1'bx; r4 = 1'bx; g3 = 0; g4 = 0;
        for (int n = 0; n < 12; n++) begin
            credit_in[0] = (n < 3);
            step();
            if (q_data.size() == 3 && !g3) begin r3 = tready[0]; g3 = 1; end
            if (q_data.size() == 4 && !g4) begin r4 = tready[0]; g4 = 1; end
        end
        credit_in = '0;
        check("t5_ready_before_pop", r3, 0);
        check("t5_ready_after_pop", r4, 1);
        if (q_data.size() == 4) check("t5_f3", q_data[3], flit(8'h40, 3));

        // 6: reset mid-word
        do_reset();
        clear_q();
        push_word(0, 8'h11, 3'd6, 1'b1);
        step();
        step();
        check("t6_pre_flits", q_data.size(), 2);
        rst_n = 1'b0;
        #1;
        check("t6_send", send_out, 0);
        check("t6_data", data_out, 0);
        check("t6_dest", dest_out, 0);
        check("t6_tready", tready, 4'hF);
        release_reset();
        clear_q();
        push_word(0, 8'h77, 3'd7, 1'b1);
        repeat (8) step();
        check("t6_nflit", q_data.size(), 4);
        if (q_data.size() == 4) begin
            check("t6_f0", q_data[0], flit(8'h77, 0));
            check("t6_f3", q_data[3], flit(8'h77, 3));
            check("t6_tail", q_tail[3], 1);
        end

`ifdef AXIS_SER_TRIM_EN
        do_reset();
        clear_q();
        tkeep[64 +: 64] = 64'h0000_0000_0000_FFFF;
        push_word(1, 8'h33, 3'd2, 1'b1);
        repeat (6) step();
        tkeep = '0;
        check("trim_nflit", q_data.size(), 1);
        if (q_data.size() == 1) begin
            check("trim_tail", q_tail[0], 1);
            check("trim_data", q_data[0], flit(8'h33, 0));
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
